// File: rtl/scan_bcd_counter_pkg.sv
// Shared types and helpers for the two-digit BCD counter and its display scanner.
package scan_bcd_counter_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int         SEL_W   = 3;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CLR,
    ACT_LOAD,
    ACT_REJECT,
    ACT_UP,
    ACT_DOWN
  } count_act_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= BCD_MAX) && (v[3:0] <= BCD_MAX);
  endfunction

  // Only meaningful for values that already passed bcd_valid().
  function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
    return (7'(v[7:4]) * 7'd10) + 7'(v[3:0]);
  endfunction

endpackage

// File: rtl/scan_bcd_counter_tick.sv
// Free-running modulo-DIV divider producing a one-cycle tick on its last count.
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic sclr,
  output logic tick
);

  localparam int            CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = run && (r_cnt == LAST);

  // A synchronous clear wins over both the wrap and the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (sclr) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/scan_bcd_counter.sv
// Two-digit modulo-N BCD counter with load/clear, plus the digit-select scan generator.
module scan_bcd_counter
  import scan_bcd_counter_pkg::*;
#(
  parameter int PRESCALE   = 50_000_000,
  parameter int SCAN_DIV   = 50_000,
  parameter int MOD_VALUE  = 60,
  parameter int NUM_DIGITS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       carry,
  output logic       load_err,
  output logic [2:0] select,
  output logic       scan_en
);

  localparam logic [6:0]       MOD_BIN  = 7'(MOD_VALUE);
  localparam logic [3:0]       MAX_TENS = 4'((MOD_VALUE - 1) / 10);
  localparam logic [3:0]       MAX_ONES = 4'((MOD_VALUE - 1) % 10);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

  bcd2_t            r_count;
  logic             r_carry;
  logic             r_load_err;
  logic [SEL_W-1:0] r_sel;
  logic             r_scan_en;

  logic       w_load_ok;
  logic       w_pre_sclr;
  logic       w_count_tick;
  logic       w_scan_tick;
  logic       w_at_max;
  logic       w_at_zero;
  logic       w_wrap;
  count_act_e w_act;
  bcd2_t      w_next;

  assign w_load_ok  = bcd_valid(load_val) && (bcd_to_bin(load_val) < MOD_BIN);
  assign w_pre_sclr = clr | (load & w_load_ok);
  assign w_at_max   = (r_count.tens == MAX_TENS) && (r_count.ones == MAX_ONES);
  assign w_at_zero  = (r_count.tens == 4'd0) && (r_count.ones == 4'd0);

  tick_divider #(.DIV(PRESCALE)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (en),
    .sclr  (w_pre_sclr),
    .tick  (w_count_tick)
  );

  tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (1'b1),
    .sclr  (1'b0),
    .tick  (w_scan_tick)
  );

  always_comb begin
    w_act = ACT_HOLD;
    if (clr) begin
      w_act = ACT_CLR;
    end else if (load) begin
      w_act = w_load_ok ? ACT_LOAD : ACT_REJECT;
    end else if (w_count_tick) begin
      w_act = up ? ACT_UP : ACT_DOWN;
    end
  end

  // Digit carries/borrows are handled nibble-wise so the count never leaves BCD.
  always_comb begin
    w_next = r_count;
    w_wrap = 1'b0;
    case (w_act)
      ACT_CLR: begin
        w_next = '0;
      end
      ACT_LOAD: begin
        w_next = load_val;
      end
      ACT_UP: begin
        if (w_at_max) begin
          w_next = '0;
          w_wrap = 1'b1;
        end else if (r_count.ones == BCD_MAX) begin
          w_next.ones = 4'd0;
          w_next.tens = r_count.tens + 4'd1;
        end else begin
          w_next.ones = r_count.ones + 4'd1;
        end
      end
      ACT_DOWN: begin
        if (w_at_zero) begin
          w_next.tens = MAX_TENS;
          w_next.ones = MAX_ONES;
          w_wrap      = 1'b1;
        end else if (r_count.ones == 4'd0) begin
          w_next.ones = BCD_MAX;
          w_next.tens = r_count.tens - 4'd1;
        end else begin
          w_next.ones = r_count.ones - 4'd1;
        end
      end
      default: begin
        w_next = r_count;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_carry    <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_count    <= w_next;
      r_carry    <= w_wrap;
      r_load_err <= (w_act == ACT_REJECT);
    end
  end

  // scan_en is registered alongside select so the pulse lines up with the change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel     <= '0;
      r_scan_en <= 1'b0;
    end else begin
      r_scan_en <= w_scan_tick;
      if (w_scan_tick) begin
        r_sel <= (r_sel == SEL_LAST) ? '0 : r_sel + SEL_W'(1);
      end
    end
  end

  assign ones     = r_count.ones;
  assign tens     = r_count.tens;
  assign carry    = r_carry;
  assign load_err = r_load_err;
  assign select   = r_sel;
  assign scan_en  = r_scan_en;

endmodule

// File: tb/tb_scan_bcd_counter.sv
// Directed bench for scan_bcd_counter: a MOD 60 instance and a MOD 100 instance on shared inputs.
module tb_scan_bcd_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       clr;
  logic       load;
  logic [7:0] load_val;

  logic [3:0] ones,  tens;
  logic       carry, load_err, scan_en;
  logic [2:0] select;

  logic [3:0] ones100, tens100;
  logic       carry100, loadErr100, scanEn100;
  logic [2:0] select100;

  int vectors    = 0;
  int miscompares = 0;
  int cycleCount = 0;

  logic [2:0] selTable [0:24] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4,
                                  3'd5, 3'd5, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3,
                                  3'd4, 3'd4, 3'd5, 3'd5, 3'd0};
  logic [7:0] downTable [0:5] = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h59};

  scan_bcd_counter #(
    .PRESCALE(4), .SCAN_DIV(2), .MOD_VALUE(60), .NUM_DIGITS(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .ones(ones), .tens(tens), .carry(carry),
    .load_err(load_err), .select(select), .scan_en(scan_en)
  );

  scan_bcd_counter #(
    .PRESCALE(4), .SCAN_DIV(2), .MOD_VALUE(100), .NUM_DIGITS(6)
  ) dut100 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .ones(ones100), .tens(tens100), .carry(carry100),
    .load_err(loadErr100), .select(select100), .scan_en(scanEn100)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic u, input logic c,
                               input logic l, input logic [7:0] v);
    en       = e;
    up       = u;
    clr      = c;
    load     = l;
    load_val = v;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      cycleCount++;
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #2;
    checkOutput("rst_count60", {24'd0, tens, ones}, 32'h00);
    checkOutput("rst_flags60", {28'd0, carry, load_err, scan_en, 1'b0}, 32'h0);
    checkOutput("rst_select60", {29'd0, select}, 32'd0);
    checkOutput("rst_count100", {24'd0, tens100, ones100}, 32'h00);
    @(negedge clk);
    rst_n      = 1'b1;
    cycleCount = 0;
  endtask

  initial begin
    int t;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);

    $display("[TB] reset and count up through a full MOD 60 cycle");
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= 240; k++) begin
      waitCycles(1);
      t = k / 4;
      checkOutput($sformatf("up_count_k%0d", k), {24'd0, tens, ones},
                  32'(((t % 60) / 10) * 16 + (t % 10)));
      checkOutput($sformatf("up_carry_k%0d", k), {31'd0, carry}, {31'd0, (k == 240)});
    end

    $display("[TB] load 05 then count down through the wrap");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h05);
    waitCycles(1);
    checkOutput("load05", {24'd0, tens, ones}, 32'h05);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      waitCycles(3);
      checkOutput($sformatf("down_hold_%0d", i), {24'd0, tens, ones},
                  (i == 0) ? 32'h05 : {24'd0, downTable[i-1]});
      waitCycles(1);
      checkOutput($sformatf("down_count_%0d", i), {24'd0, tens, ones}, {24'd0, downTable[i]});
      checkOutput($sformatf("down_carry_%0d", i), {31'd0, carry}, {31'd0, (i == 5)});
    end
    waitCycles(1);
    checkOutput("down_carry_drop", {31'd0, carry}, 32'd0);

    $display("[TB] rejected and accepted loads");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h3A);
    waitCycles(1);
    checkOutput("rej3A_err", {31'd0, load_err}, 32'd1);
    checkOutput("rej3A_count", {24'd0, tens, ones}, 32'h59);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    waitCycles(1);
    checkOutput("rej3A_err_drop", {31'd0, load_err}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h75);
    waitCycles(1);
    checkOutput("rej75_err", {31'd0, load_err}, 32'd1);
    checkOutput("rej75_count", {24'd0, tens, ones}, 32'h59);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h42);
    waitCycles(1);
    checkOutput("load42_count", {24'd0, tens, ones}, 32'h42);
    checkOutput("load42_err", {31'd0, load_err}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h59);
    waitCycles(1);
    checkOutput("load59_count", {24'd0, tens, ones}, 32'h59);

    $display("[TB] clear and load colliding with a wrapping tick, then frozen count");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    waitCycles(3);
    checkOutput("pretick_count", {24'd0, tens, ones}, 32'h59);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h12);
    waitCycles(1);
    checkOutput("clr_count", {24'd0, tens, ones}, 32'h00);
    checkOutput("clr_carry", {31'd0, carry}, 32'd0);
    checkOutput("clr_err", {31'd0, load_err}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 20; k++) begin
      waitCycles(1);
      checkOutput($sformatf("frozen_count_%0d", k), {24'd0, tens, ones}, 32'h00);
      checkOutput($sformatf("frozen_sel_%0d", k), {29'd0, select},
                  32'((cycleCount / 2) % 6));
    end

    $display("[TB] select sequence and asynchronous reset");
    doReset();
    for (int k = 1; k <= 24; k++) begin
      waitCycles(1);
      checkOutput($sformatf("scan_sel_%0d", k), {29'd0, select}, {29'd0, selTable[k]});
      checkOutput($sformatf("scan_en_%0d", k), {31'd0, scan_en}, {31'd0, (k % 2 == 0)});
    end
    waitCycles(7);
    checkOutput("scan_sel_prereset", {29'd0, select}, 32'd3);
    doReset();

    $display("[TB] MOD 100 wrap");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= 100; k++) begin
      waitCycles(4);
      t = k % 100;
      checkOutput($sformatf("mod100_count_%0d", k), {24'd0, tens100, ones100},
                  32'((t / 10) * 16 + (t % 10)));
      checkOutput($sformatf("mod100_carry_%0d", k), {31'd0, carry100}, {31'd0, (k == 100)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
